dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage. It sits directly downstream of the EX/MEM pipeline register and replaces the single-cycle data memory. It serves load hits in the same cycle and forwards misses and all stores to a multi-cycle backing memory over a req/ack handshake. It raises `stall_o` to freeze the pipeline while memory is outstanding.

---
 rtl/dcache_ctrl.sv | 138 +++++++++++++
 tb/tb_dcache_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller for the MEM stage. Load hits are served combinationally; load
// misses and every store go to a multi-cycle backing memory over req/ack,
// with stall_o freezing the pipeline while memory is outstanding.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    RMISS,
    WRITE
  } state_t;

  state_t state_q;
  state_t next_state;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             capture;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;

  // The byte-offset bits never reach the word-organised cache or memory.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr_i[1:0];

  assign index = addr_i[IDX_W+1:2];
  assign tag   = addr_i[31:IDX_W+2];
  assign hit   = valid_q[index] && (tag_q[index] == tag);

  assign data_o      = hit ? data_q[index] : 32'h0;
  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Request registers load only when leaving IDLE; the pipeline is frozen after that.
  assign capture = (state_q == IDLE) && (next_state != IDLE);

  // State register; reset drops the request immediately since mem_req_o decodes the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and stall: stores win over loads, read hits never leave IDLE.
  always_comb begin
    next_state = state_q;
    stall_o    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = (MemRead_i & ~hit) | MemWrite_i;
        if (MemWrite_i) begin
          next_state = WRITE;
        end else if (MemRead_i && !hit) begin
          next_state = RMISS;
        end
      end
      RMISS: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        stall_o = ~mem_ack_i;
        if (mem_ack_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Backing-memory request registers, held constant for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
    end else if (capture) begin
      mem_addr_q  <= {addr_i[31:2], 2'b00};
      mem_wdata_q <= write_data_i;
      mem_we_q    <= MemWrite_i;
    end
  end

  // Valid bits: cleared by reset, set when a read miss is filled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if ((state_q == RMISS) && mem_ack_i) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag/data storage: filled on read-miss ack, updated on store ack only when the store hits.
  always_ff @(posedge clk_i) begin
    if ((state_q == RMISS) && mem_ack_i) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_rdata_i;
    end else if ((state_q == WRITE) && mem_ack_i && hit) begin
      data_q[index] <= mem_wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: cycle-by-cycle vector table for the dcache_ctrl FSM plus a
// hand-written reset-during-miss sequence.
module tb_dcache_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_stall;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  dcache_ctrl #(.LINES(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                              input logic exp_stall, input logic exp_req, input logic exp_we,
                              input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                              input logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
    v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_we = exp_we;
    v.exp_maddr = exp_maddr; v.exp_mwdata = exp_mwdata; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
    MemRead_i    = rd;
    MemWrite_i   = wr;
    addr_i       = addr;
    write_data_i = wdata;
    mem_ack_i    = ack;
    mem_rdata_i  = rdata;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_stall, input logic e_req, input logic e_we,
                           input logic [31:0] e_maddr, input logic [31:0] e_mwdata, input logic [31:0] e_data);
    check_output({tag, " stall"}, {31'h0, stall_o},   {31'h0, e_stall});
    check_output({tag, " req"},   {31'h0, mem_req_o}, {31'h0, e_req});
    check_output({tag, " we"},    {31'h0, mem_we_o},  {31'h0, e_we});
    check_output({tag, " maddr"}, mem_addr_o,  e_maddr);
    check_output({tag, " mwdata"}, mem_wdata_o, e_mwdata);
    check_output({tag, " data"},  data_o,      e_data);
  endtask

  initial begin
    //              rd   wr   addr          wdata         ack  rdata         stl  req  we   maddr         mwdata        data
    // cold read miss of 0x40, ack two cycles after request
    vecs[0]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[2]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[3]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b1,32'hDEADBEEF, 1'b1,1'b1,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[4]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0000_0040,32'h0,        32'hDEADBEEF);
    // read hit again
    vecs[5]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0000_0040,32'h0,        32'hDEADBEEF);
    // store hit 0x12345678 to 0x40, ack one cycle after request
    vecs[6]  = mk(1'b0,1'b1,32'h0000_0040,32'h12345678, 1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0000_0040,32'h0,        32'hDEADBEEF);
    vecs[7]  = mk(1'b0,1'b1,32'h0000_0040,32'h12345678, 1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0000_0040,32'h12345678, 32'hDEADBEEF);
    vecs[8]  = mk(1'b0,1'b1,32'h0000_0040,32'h12345678, 1'b1,32'h0,        1'b0,1'b1,1'b1,32'h0000_0040,32'h12345678, 32'hDEADBEEF);
    vecs[9]  = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0000_0040,32'h12345678, 32'h12345678);
    // conflict eviction: 0xC0 and 0x40 share index 16
    vecs[10] = mk(1'b1,1'b0,32'h0000_00C0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'h0000_0040,32'h12345678, 32'h0);
    vecs[11] = mk(1'b1,1'b0,32'h0000_00C0,32'h0,        1'b1,32'hA5A5A5A5, 1'b1,1'b1,1'b0,32'h0000_00C0,32'h0,        32'h0);
    vecs[12] = mk(1'b1,1'b0,32'h0000_00C0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0000_00C0,32'h0,        32'hA5A5A5A5);
    vecs[13] = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0000_00C0,32'h0,        32'h0);
    vecs[14] = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[15] = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b1,32'hCAFEF00D, 1'b1,1'b1,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[16] = mk(1'b1,1'b0,32'h0000_0040,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0000_0040,32'h0,        32'hCAFEF00D);
    // store miss to 0x200 (ack in first request cycle), then read misses
    vecs[17] = mk(1'b0,1'b1,32'h0000_0200,32'h11,       1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0000_0040,32'h0,        32'h0);
    vecs[18] = mk(1'b0,1'b1,32'h0000_0200,32'h11,       1'b1,32'h0,        1'b0,1'b1,1'b1,32'h0000_0200,32'h11,       32'h0);
    vecs[19] = mk(1'b1,1'b0,32'h0000_0200,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'h0000_0200,32'h11,       32'h0);
    vecs[20] = mk(1'b1,1'b0,32'h0000_0200,32'h0,        1'b1,32'h77,       1'b1,1'b1,1'b0,32'h0000_0200,32'h0,        32'h0);
    vecs[21] = mk(1'b1,1'b0,32'h0000_0200,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0000_0200,32'h0,        32'h77);
    // read+write together is a store; then a back-to-back store
    vecs[22] = mk(1'b1,1'b1,32'h0000_0200,32'hAB,       1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        32'h77);
    vecs[23] = mk(1'b1,1'b1,32'h0000_0200,32'hAB,       1'b1,32'h0,        1'b0,1'b1,1'b1,32'h0000_0200,32'hAB,       32'h77);
    vecs[24] = mk(1'b0,1'b1,32'h0000_0200,32'hCD,       1'b0,32'h0,        1'b1,1'b0,1'b1,32'h0000_0200,32'hAB,       32'hAB);
    vecs[25] = mk(1'b0,1'b1,32'h0000_0200,32'hCD,       1'b1,32'h0,        1'b0,1'b1,1'b1,32'h0000_0200,32'hCD,       32'hAB);
    vecs[26] = mk(1'b1,1'b0,32'h0000_0200,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0000_0200,32'hCD,       32'hCD);
    // stray ack in IDLE is ignored
    vecs[27] = mk(1'b0,1'b0,32'h0000_0200,32'h0,        1'b1,32'h5A5A5A5A, 1'b0,1'b0,1'b1,32'h0000_0200,32'hCD,       32'hCD);
    vecs[28] = mk(1'b0,1'b0,32'h0000_0200,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0000_0200,32'hCD,       32'hCD);

    rst_i = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk_i);
      #1;
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].exp_stall, vecs[i].exp_req, vecs[i].exp_we,
                vecs[i].exp_maddr, vecs[i].exp_mwdata, vecs[i].exp_data);
    end

    // Reset in the middle of a read miss (0x1C0 maps to the same line as 0x40)
    @(posedge clk_i);
    #1;
    apply_stimulus(1'b1, 1'b0, 32'h0000_01C0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("rst_mid detect stall", {31'h0, stall_o},   32'h1);
    @(posedge clk_i);
    #1;
    check_output("rst_mid rmiss req", {31'h0, mem_req_o}, 32'h1);
    check_output("rst_mid rmiss maddr", mem_addr_o, 32'h0000_01C0);
    #1;
    apply_stimulus(1'b0, 1'b0, 32'h0000_01C0, 32'h0, 1'b0, 32'h0);
    rst_i = 1'b0;
    #1;
    check_all("rst_mid async", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0000_01C0, 32'h0, 1'b1, 32'h99);
    #1;
    check_output("late_ack req", {31'h0, mem_req_o}, 32'h0);
    check_output("late_ack stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i);
    #1;
    apply_stimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
    #1;
    check_all("post_rst read40", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk_i);
    #1;
    check_all("post_rst rmiss", 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5555AAAA);
    #1;
    check_output("post_rst ack stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk_i);
    #1;
    apply_stimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
    #1;
    check_all("post_rst hit", 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h5555AAAA);

    @(posedge clk_i);
    #1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
